fifo_gearbox_40to32: RTL and testbench

Downstream stage of the 40-bit × 1024 synchronous sample FIFO: pops 40-bit words through the FIFO's non-FWFT read port and repacks the bitstream into 32-bit words on a valid/ready stream toward the communication/readout logic. Every 4 FIFO words yield 5 output words with no gaps or padding. A FLUSH request drains the block and closes the stream with a zero-padded last word when the bit count is not a multiple of 32.

---
 rtl/fifo_gearbox_40to32.sv | 126 ++++++++++++
 tb/tb_fifo_gearbox_40to32.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_gearbox_40to32.sv
// fifo_gearbox_40to32: pops 40-bit words from a non-FWFT FIFO read port
// and repacks the LSB-first bitstream into a 32-bit valid/ready stream.
module fifo_gearbox_40to32 #(
    parameter int READ_LATENCY = 1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        FIFO_EMPTY,
    output logic        FIFO_RE,
    input  logic [39:0] FIFO_Q,
    input  logic        FLUSH,
    output logic [31:0] OUT_DATA,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic        OUT_LAST,
    output logic        FLUSH_DONE
);

    localparam logic [1:0] RUN   = 2'd0;
    localparam logic [1:0] DRAIN = 2'd1;
    localparam logic [1:0] PAD   = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]              state;
    logic [1:0]              state_d;
    logic [119:0]            acc;
    logic [119:0]            acc_d;
    logic [6:0]              fill;
    logic [6:0]              fill_post;
    logic [6:0]              fill_d;
    logic [1:0]              inflight;
    logic [1:0]              inflight_d;
    logic [READ_LATENCY-1:0] rd_pipe;
    logic                    arrive;
    logic                    out_hs;
    logic [7:0]              need;

    // A FIFO word is on FIFO_Q when the matching read reaches the pipe end.
    assign arrive = rd_pipe[READ_LATENCY-1];

    assign OUT_VALID  = (fill >= 7'd32) || (state == PAD);
    assign OUT_DATA   = acc[31:0];
    assign FLUSH_DONE = (state == DONE);
    assign OUT_LAST   = (state == PAD) ||
                        ((state == DRAIN) && (inflight == 2'd0) &&
                         (fill == 7'd32));

    assign out_hs = OUT_VALID && OUT_READY;

    // Fill level after this cycle's output handshake, before any arrival.
    assign fill_post = !out_hs        ? fill :
                       (state == PAD) ? 7'd0 :
                                        fill - 7'd32;

    // Room needed if one more read is issued on top of those in flight.
    assign need = {1'b0, fill_post} +
                  8'd40 * ({6'd0, inflight} + 8'd1);

    assign FIFO_RE = !RESET && (state == RUN) && !FIFO_EMPTY &&
                     (need <= 8'd120);

    assign inflight_d = inflight + {1'b0, FIFO_RE} - {1'b0, arrive};

    // Datapath: drop the emitted word, then append any arriving word at fill.
    always_comb begin
        acc_d  = acc;
        fill_d = fill_post;
        if (out_hs) begin
            if (state == PAD) begin
                acc_d = '0;
            end else begin
                acc_d = acc >> 32;
            end
        end
        if (arrive) begin
            acc_d  = acc_d | ({80'd0, FIFO_Q} << fill_post);
            fill_d = fill_post + 7'd40;
        end
    end

    // Flush control; DRAIN looks at next-cycle levels so DONE follows promptly.
    always_comb begin
        state_d = state;
        case (state)
            RUN: begin
                if (FLUSH) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if ((inflight_d == 2'd0) && (fill_d < 7'd32)) begin
                    state_d = (fill_d == 7'd0) ? DONE : PAD;
                end
            end
            PAD: begin
                if (out_hs) begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // State, buffer and read-tracking registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= RUN;
            acc      <= '0;
            fill     <= 7'd0;
            inflight <= 2'd0;
            rd_pipe  <= '0;
        end else begin
            state    <= state_d;
            acc      <= acc_d;
            fill     <= fill_d;
            inflight <= inflight_d;
            rd_pipe[0] <= FIFO_RE;
            for (int i = 1; i < READ_LATENCY; i++) begin
                rd_pipe[i] <= rd_pipe[i-1];
            end
        end
    end

endmodule

// File: tb/tb_fifo_gearbox_40to32.sv
// tb_fifo_gearbox_40to32: directed bench with a latency-1 FIFO model
// and hand-computed expected words for the 40-to-32 gearbox.
module tb_fifo_gearbox_40to32;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        FLUSH = 1'b0;
    logic        OUT_READY = 1'b1;
    logic        FIFO_RE;
    logic        FIFO_EMPTY;
    logic [39:0] FIFO_Q = '0;
    logic [31:0] OUT_DATA;
    logic        OUT_VALID;
    logic        OUT_LAST;
    logic        FLUSH_DONE;

    int n_vec = 0;
    int n_bad = 0;

    logic [39:0] mem [0:63];
    int          wp = 0;
    int          rp = 0;

    logic [32:0] oq_d [0:63];
    int          oq_n = 0;

    logic [31:0] ref_w [0:4];
    logic [39:0] w_in  [0:3];
    int          base;

    fifo_gearbox_40to32 #(.READ_LATENCY(1)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .FIFO_EMPTY (FIFO_EMPTY),
        .FIFO_RE    (FIFO_RE),
        .FIFO_Q     (FIFO_Q),
        .FLUSH      (FLUSH),
        .OUT_DATA   (OUT_DATA),
        .OUT_VALID  (OUT_VALID),
        .OUT_READY  (OUT_READY),
        .OUT_LAST   (OUT_LAST),
        .FLUSH_DONE (FLUSH_DONE)
    );

    always #5 CLK = ~CLK;

    assign FIFO_EMPTY = (wp == rp);

    // Non-FWFT FIFO read port: data appears one cycle after the read.
    always @(posedge CLK) begin
        if (FIFO_RE && (wp != rp)) begin
            FIFO_Q <= mem[rp];
            rp     <= rp + 1;
        end
    end

    // Record every accepted output word with its LAST flag.
    always @(negedge CLK) begin
        if ((OUT_VALID === 1'b1) && OUT_READY && (oq_n < 64)) begin
            oq_d[oq_n] <= {OUT_LAST, OUT_DATA};
            oq_n       <= oq_n + 1;
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input logic [39:0] w);
        mem[wp] = w;
        wp = wp + 1;
    endtask

    task automatic chk(input string tag,
                       input logic [39:0] obs,
                       input logic [39:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        ref_w[0] = 32'h11111111;
        ref_w[1] = 32'h222222AA;
        ref_w[2] = 32'h3333BB22;
        ref_w[3] = 32'h44CC3333;
        ref_w[4] = 32'hDD444444;
        w_in[0]  = 40'hAA11111111;
        w_in[1]  = 40'hBB22222222;
        w_in[2]  = 40'hCC33333333;
        w_in[3]  = 40'hDD44444444;

        // Reset held 3 cycles with data waiting in the FIFO.
        for (int i = 0; i < 4; i++) push(w_in[i]);
        repeat (3) begin
            step();
            chk("rst_re", 40'(FIFO_RE), 40'd0);
            chk("rst_valid", 40'(OUT_VALID), 40'd0);
            chk("rst_last", 40'(OUT_LAST), 40'd0);
            chk("rst_done", 40'(FLUSH_DONE), 40'd0);
            chk("rst_data", 40'(OUT_DATA), 40'd0);
        end
        chk("rst_state", 40'(dut.state), 40'd0);
        chk("rst_fill", 40'(dut.fill), 40'd0);
        chk("rst_inflight", 40'(dut.inflight), 40'd0);
        chk("rst_fifo_untouched", 40'(rp), 40'd0);

        // Packing of one 4-word group with OUT_READY high.
        base = oq_n;
        RESET = 1'b0;
        #1;
        chk("first_re", 40'(FIFO_RE), 40'd1);
        step();
        chk("lat_valid_c1", 40'(OUT_VALID), 40'd0);
        step();
        chk("lat_valid_c2", 40'(OUT_VALID), 40'd1);
        chk("lat_data_c2", 40'(OUT_DATA), 40'h11111111);
        repeat (6) step();
        chk("pack_count", 40'(oq_n - base), 40'd5);
        for (int i = 0; i < 5; i++) begin
            chk("pack_word", 40'(oq_d[base+i]), 40'({1'b0, ref_w[i]}));
        end
        chk("pack_idle_valid", 40'(OUT_VALID), 40'd0);
        chk("pack_idle_fill", 40'(dut.fill), 40'd0);

        // Backpressure: 8 words, OUT_READY low for 10 cycles mid-stream.
        base = oq_n;
        for (int g = 0; g < 2; g++) begin
            for (int i = 0; i < 4; i++) push(w_in[i]);
        end
        repeat (4) step();
        OUT_READY = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("stall_valid", 40'(OUT_VALID), 40'd1);
            chk("stall_data", 40'(OUT_DATA), 40'h3333BB22);
            chk("stall_last", 40'(OUT_LAST), 40'd0);
            chk("stall_re", 40'(FIFO_RE), 40'd0);
            chk("stall_room",
                40'((dut.fill + 40 * dut.inflight) <= 120), 40'd1);
            step();
        end
        chk("stall_fill", 40'(dut.fill), 40'd96);
        chk("stall_inflight", 40'(dut.inflight), 40'd0);
        OUT_READY = 1'b1;
        repeat (20) step();
        chk("bp_count", 40'(oq_n - base), 40'd10);
        for (int i = 0; i < 10; i++) begin
            chk("bp_word", 40'(oq_d[base+i]),
                40'({1'b0, ref_w[i%5]}));
        end
        chk("bp_idle_valid", 40'(OUT_VALID), 40'd0);
        chk("bp_idle_fill", 40'(dut.fill), 40'd0);

        // Flush with an 8-bit residue.
        base = oq_n;
        push(w_in[0]);
        step();
        step();
        FLUSH = 1'b1;
        #1;
        chk("res_w0_data", 40'(OUT_DATA), 40'h11111111);
        chk("res_w0_last", 40'(OUT_LAST), 40'd0);
        step();
        FLUSH = 1'b0;
        #1;
        chk("res_gap_valid", 40'(OUT_VALID), 40'd0);
        chk("res_gap_state", 40'(dut.state), 40'd1);
        step();
        chk("res_pad_valid", 40'(OUT_VALID), 40'd1);
        chk("res_pad_last", 40'(OUT_LAST), 40'd1);
        chk("res_pad_data", 40'(OUT_DATA), 40'h000000AA);
        chk("res_pad_done", 40'(FLUSH_DONE), 40'd0);
        step();
        chk("res_done", 40'(FLUSH_DONE), 40'd1);
        chk("res_done_valid", 40'(OUT_VALID), 40'd0);
        step();
        chk("res_done_pulse", 40'(FLUSH_DONE), 40'd0);
        chk("res_count", 40'(oq_n - base), 40'd2);
        chk("res_q0", 40'(oq_d[base]), 40'h0011111111);
        chk("res_q1", 40'(oq_d[base+1]), 40'h01000000AA);

        // Aligned flush after a full group: LAST on the fifth word.
        base = oq_n;
        for (int i = 0; i < 4; i++) push(w_in[i]);
        repeat (5) step();
        FLUSH = 1'b1;
        #1;
        chk("al_w3_data", 40'(OUT_DATA), 40'h44CC3333);
        chk("al_w3_last", 40'(OUT_LAST), 40'd0);
        step();
        FLUSH = 1'b0;
        #1;
        chk("al_w4_data", 40'(OUT_DATA), 40'hDD444444);
        chk("al_w4_last", 40'(OUT_LAST), 40'd1);
        chk("al_w4_valid", 40'(OUT_VALID), 40'd1);
        step();
        chk("al_done", 40'(FLUSH_DONE), 40'd1);
        chk("al_done_valid", 40'(OUT_VALID), 40'd0);
        chk("al_count", 40'(oq_n - base), 40'd5);
        for (int i = 0; i < 5; i++) begin
            chk("al_word", 40'(oq_d[base+i]),
                40'({(i == 4), ref_w[i]}));
        end

        // Empty flush, plus a FLUSH during DONE that must be ignored.
        step();
        base = oq_n;
        FLUSH = 1'b1;
        #1;
        chk("ef_valid0", 40'(OUT_VALID), 40'd0);
        step();
        FLUSH = 1'b0;
        #1;
        chk("ef_done1", 40'(FLUSH_DONE), 40'd0);
        chk("ef_valid1", 40'(OUT_VALID), 40'd0);
        step();
        chk("ef_done2", 40'(FLUSH_DONE), 40'd1);
        chk("ef_valid2", 40'(OUT_VALID), 40'd0);
        FLUSH = 1'b1;
        step();
        FLUSH = 1'b0;
        #1;
        chk("ef_done3", 40'(FLUSH_DONE), 40'd0);
        chk("ef_state3", 40'(dut.state), 40'd0);
        step();
        chk("ef_done4", 40'(FLUSH_DONE), 40'd0);
        chk("ef_state4", 40'(dut.state), 40'd0);
        chk("ef_no_words", 40'(oq_n - base), 40'd0);

        // Reset in DRAIN with 24 residue bits and OUT_READY low.
        base = oq_n;
        for (int i = 0; i < 3; i++) push(w_in[i]);
        repeat (5) step();
        chk("rd_pre_fill", 40'(dut.fill), 40'd24);
        chk("rd_pre_inflight", 40'(dut.inflight), 40'd0);
        chk("rd_words", 40'(oq_n - base), 40'd3);
        for (int i = 0; i < 3; i++) begin
            chk("rd_word", 40'(oq_d[base+i]), 40'({1'b0, ref_w[i]}));
        end
        FLUSH = 1'b1;
        OUT_READY = 1'b0;
        step();
        FLUSH = 1'b0;
        #1;
        chk("rd_drain_state", 40'(dut.state), 40'd1);
        chk("rd_drain_fill", 40'(dut.fill), 40'd24);
        RESET = 1'b1;
        step();
        chk("rd_post_valid", 40'(OUT_VALID), 40'd0);
        chk("rd_post_state", 40'(dut.state), 40'd0);
        chk("rd_post_fill", 40'(dut.fill), 40'd0);
        RESET = 1'b0;
        OUT_READY = 1'b1;
        base = oq_n;
        push(w_in[0]);
        repeat (4) step();
        chk("rd_new_count", 40'(oq_n - base), 40'd1);
        chk("rd_new_word", 40'(oq_d[base]), 40'h0011111111);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
